uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
//
// Recovers bytes from the asynchronous rx pin. Each correctly framed byte is
// presented on po_data with a one-cycle po_flag strobe. That is the same
// handshake the transmitter accepts, so the two blocks chain directly.
// A low stop bit gives a one-cycle frame_err pulse instead of po_flag.
//
// Parameters
//   UART_BPS  line baud rate
//   CLK_FREQ  sys_clk frequency in Hz (CLK_FREQ / UART_BPS must be 4..65535)
//
// Ports
//   sys_clk    system clock
//   sys_rst    synchronous active-high reset
//   rx         asynchronous serial line, idle high
//   po_data    last correctly framed byte (LSB first on the line)
//   po_flag    one-cycle pulse when po_data is updated
//   frame_err  one-cycle pulse when the stop bit is sampled low
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | checking the start bit at mid-bit (rejects glitches)
// DATA  | sampling 8 data bits at mid-bit, LSB first
// STOP  | checking the stop bit; publishes the byte or flags a framing error

module uart_rx #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err
);

    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF         = BAUD_CNT_MAX / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] HALF_CNT  = 16'(HALF);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        s1;
    logic        s2;
    logic        s3;
    logic        s1_live;
    logic        armed;
    logic [15:0] baud_cnt;
    logic [3:0]  bit_cnt;
    logic [7:0]  shift;
    logic        start_edge;
    logic        strobe;

    // The synchronizer resets high, so a line held low through reset release
    // would look like a falling edge. Start detection stays disarmed until s1
    // has captured a real high level from the line after reset.
    assign start_edge = armed && !s2 && s3;
    assign strobe     = (state != IDLE) && (baud_cnt == HALF_CNT);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            s3      <= 1'b1;
            s1_live <= 1'b0;
            armed   <= 1'b0;
        end else begin
            s1      <= rx;
            s2      <= s1;
            s3      <= s2;
            s1_live <= 1'b1;
            if (s1_live && s1) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (strobe) begin
                    state_nxt = s3 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (strobe && (bit_cnt == 4'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
                if (strobe) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            baud_cnt  <= 16'd0;
            bit_cnt   <= 4'd0;
            shift     <= 8'h00;
            po_data   <= 8'h00;
            po_flag   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            po_flag   <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE) begin
                baud_cnt <= 16'd0;
                bit_cnt  <= 4'd0;
            end else if (baud_cnt == BAUD_LAST) begin
                baud_cnt <= 16'd0;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end

            if ((state == DATA) && strobe) begin
                shift   <= {s3, shift[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end

            if ((state == STOP) && strobe) begin
                if (s3) begin
                    po_data <= shift;
                    po_flag <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx at 10 clocks per bit (HALF = 5).
// A negedge monitor records every po_flag / frame_err cycle; each scenario
// task drives the line and compares the recorded events with hand-computed
// values.

module tb_uart_rx;

    localparam int BIT = 10;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;

    int total    = 0;
    int bad      = 0;
    int cyc      = 0;
    int flag_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;
    logic [7:0] data_q[$];
    int         cyc_q[$];

    uart_rx #(
        .UART_BPS(5_000_000),
        .CLK_FREQ(50_000_000)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx       (rx),
        .po_data  (po_data),
        .po_flag  (po_flag),
        .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (po_flag) begin
            flag_cnt++;
            data_q.push_back(po_data);
            cyc_q.push_back(cyc);
        end
        if (frame_err) err_cnt++;
        if (po_flag && frame_err) both_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
        rx = stop_bit;
        tick(BIT);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        rx = 1'b1;
        tick(2);
        total++; if (po_data !== 8'h00) begin bad++; $display("FAIL reset_po_data: got %h want 00", po_data); end
        total++; if (po_flag !== 1'b0) begin bad++; $display("FAIL reset_po_flag: got %b want 0", po_flag); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dut.state); end
        sys_rst = 1'b0;
        tick(5);
    endtask

    task automatic test_single();
        int f0, e0, c0;
        f0 = flag_cnt; e0 = err_cnt; c0 = cyc;
        data_q.delete(); cyc_q.delete();
        send_frame(8'h55, 1'b1);
        tick(5);
        total++; if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL single_flag_count: got %0d want 1", flag_cnt - f0); end
        if (data_q.size() > 0) begin
            total++; if (data_q[0] !== 8'h55) begin bad++; $display("FAIL single_data: got %h want 55", data_q[0]); end
            total++; if (cyc_q[0] - c0 !== 99) begin bad++; $display("FAIL single_latency: got %0d want 99", cyc_q[0] - c0); end
        end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL single_frame_err: got %0d want 0", err_cnt - e0); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL single_idle: got %0d want 0", dut.state); end
    endtask

    task automatic test_back_to_back();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        data_q.delete(); cyc_q.delete();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        tick(5);
        total++; if (flag_cnt - f0 !== 2) begin bad++; $display("FAIL b2b_flag_count: got %0d want 2", flag_cnt - f0); end
        if (data_q.size() > 1) begin
            total++; if (data_q[0] !== 8'hA3) begin bad++; $display("FAIL b2b_data0: got %h want a3", data_q[0]); end
            total++; if (data_q[1] !== 8'h0F) begin bad++; $display("FAIL b2b_data1: got %h want 0f", data_q[1]); end
            total++; if (cyc_q[1] - cyc_q[0] !== 100) begin bad++; $display("FAIL b2b_spacing: got %0d want 100", cyc_q[1] - cyc_q[0]); end
        end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL b2b_frame_err: got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        data_q.delete(); cyc_q.delete();
        rx = 1'b0;
        tick(3);
        total++; if (dut.state !== 2'd1) begin bad++; $display("FAIL glitch_start_seen: got %0d want 1", dut.state); end
        rx = 1'b1;
        tick(6);
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL glitch_idle_by_d6: got %0d want 0", dut.state); end
        tick(20);
        total++; if (flag_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_no_flag: got %0d want 0", flag_cnt - f0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL glitch_no_err: got %0d want 0", err_cnt - e0); end
        send_frame(8'h81, 1'b1);
        tick(5);
        total++; if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL glitch_next_count: got %0d want 1", flag_cnt - f0); end
        total++; if (po_data !== 8'h81) begin bad++; $display("FAIL glitch_next_data: got %h want 81", po_data); end
    endtask

    task automatic test_frame_err();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        data_q.delete(); cyc_q.delete();
        send_frame(8'h3C, 1'b1);
        tick(5);
        send_frame(8'h99, 1'b0);
        tick(20);
        total++; if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL ferr_flag_count: got %0d want 1", flag_cnt - f0); end
        if (data_q.size() > 0) begin
            total++; if (data_q[0] !== 8'h3C) begin bad++; $display("FAIL ferr_first_data: got %h want 3c", data_q[0]); end
        end
        total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ferr_err_count: got %0d want 1", err_cnt - e0); end
        total++; if (po_data !== 8'h3C) begin bad++; $display("FAIL ferr_hold_data: got %h want 3c", po_data); end
    endtask

    task automatic test_reset_mid();
        int f0, e0;
        f0 = flag_cnt; e0 = err_cnt;
        rx = 1'b0;
        tick(BIT);
        rx = 1'b1;
        tick(4 * BIT + 5);
        sys_rst = 1'b1;
        tick(1);
        total++; if (po_data !== 8'h00) begin bad++; $display("FAIL midrst_po_data: got %h want 00", po_data); end
        total++; if (po_flag !== 1'b0) begin bad++; $display("FAIL midrst_po_flag: got %b want 0", po_flag); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL midrst_state: got %0d want 0", dut.state); end
        sys_rst = 1'b0;
        tick(5 + 3 * BIT + BIT + 5);
        total++; if (flag_cnt - f0 !== 0) begin bad++; $display("FAIL midrst_no_flag: got %0d want 0", flag_cnt - f0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL midrst_no_err: got %0d want 0", err_cnt - e0); end
        send_frame(8'hC6, 1'b1);
        tick(5);
        total++; if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL midrst_next_count: got %0d want 1", flag_cnt - f0); end
        total++; if (po_data !== 8'hC6) begin bad++; $display("FAIL midrst_next_data: got %h want c6", po_data); end
    endtask

    task automatic test_line_low();
        int f0, e0;
        rx = 1'b0;
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        f0 = flag_cnt; e0 = err_cnt;
        tick(50);
        total++; if (flag_cnt - f0 !== 0) begin bad++; $display("FAIL lowrst_no_flag: got %0d want 0", flag_cnt - f0); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL lowrst_no_err: got %0d want 0", err_cnt - e0); end
        total++; if (dut.state !== 2'd0) begin bad++; $display("FAIL lowrst_idle: got %0d want 0", dut.state); end
        rx = 1'b1;
        tick(20);
        send_frame(8'h5A, 1'b1);
        tick(120);
        total++; if (flag_cnt - f0 !== 1) begin bad++; $display("FAIL lowrst_flag_count: got %0d want 1", flag_cnt - f0); end
        total++; if (po_data !== 8'h5A) begin bad++; $display("FAIL lowrst_data: got %h want 5a", po_data); end
        total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL lowrst_err: got %0d want 0", err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_line_low();
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL mutual_exclusion: got %0d overlapping cycles want 0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
